player_key_decoder: RTL and testbench
=====================================

// Module: player_key_decoder
// PURPOSE
//  Converts the PS/2 keyboard byte stream into the left/right move requests for
//  the player car block. Tracks make/break codes, including the E0 extended
//  prefix, and keeps held-key state per direction. Emits rate-limited one-cycle
//  move pulses so the car moves 1 px every MOVE_DIV clocks while a key is held.
//  Sits between the PS/2 receiver and the player car-position block.
// PARAMETERS
//  MOVE_DIV   = 200_000    clocks between successive move pulses while held (>=2)
//  TIMEOUT    = 1_000_000  clocks allowed after a prefix byte before the FSM aborts
//  CODE_LEFT  = 8'h6B      extended scancode (after E0) for left arrow
//  CODE_RIGHT = 8'h74      extended scancode (after E0) for right arrow
//  ALT_LEFT   = 8'h1C      non-extended alternate left key ('A')
//  ALT_RIGHT  = 8'h23      non-extended alternate right key ('D')
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  rx_done_tick in   1  one-cycle strobe: rx_data holds a new PS/2 byte
//  rx_data      in   8  received scancode byte
//  left         out  1  one-cycle move-left pulse (registered)
//  right        out  1  one-cycle move-right pulse (registered)
//  left_held    out  1  level: a left key is currently held
//  right_held   out  1  level: a right key is currently held
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, move counter 0, timeout counter 0.
//  FSM advances only on cycles with rx_done_tick=1, except for the timeout abort.
//  - IDLE: E0->EXT; F0->BRK; ALT_LEFT/ALT_RIGHT -> set that flag; other bytes ignored.
//  - EXT: F0->EXT_BRK; CODE_LEFT/RIGHT -> set flag, go IDLE; E0 stays EXT;
//    anything else -> IDLE.
//  - BRK: ALT_LEFT/RIGHT -> clear flag, go IDLE; E0->EXT_BRK; other bytes -> IDLE.
//  - EXT_BRK: CODE_LEFT/RIGHT -> clear flag, go IDLE; other bytes -> IDLE.
//  Arrow keys and alternate keys share one flag per direction.
//  Typematic repeat makes set an already-set flag: no effect.
//  Timeout: while in EXT/BRK/EXT_BRK, a counter runs and resets on every
//  rx_done_tick. At TIMEOUT-1 the FSM returns to IDLE. Flags are unchanged.
//  Flag latency: a byte accepted in cycle N shows on left_held/right_held in N+1.
//  Move counter cnt (width clog2(MOVE_DIV)):
//  - neither flag set: cnt<=0.
//  - otherwise: cnt <= (cnt==MOVE_DIV-1) ? 0 : cnt+1.
//  Pulses: left <= left_held & (cnt==0); right <= right_held & (cnt==0).
//  - First pulse comes 1 cycle after the flag rises, i.e. cycle N+2.
//  - Later pulses repeat every MOVE_DIV cycles.
//  Both held: left and right pulse together, and the car block treats 11 as no
//  move. Releasing one key keeps cadence for the other; no counter restart.
//  Releasing all keys: no further pulses; the next press restarts at cnt=0.
//  Reset mid-sequence (e.g. after E0): FSM=IDLE, flags cleared, in-flight prefix lost.
// STRUCTURE
//  Shared package game_defs.vh holds the scancode constants (E0, F0, arrow and
//  alternate codes) and the FSM state encoding as localparams.
//  One sub-module: move_rate_tick (counter plus pulse generation, parameter
//  MOVE_DIV, inputs held_l/held_r).
//  Decoder FSM and flags live in the top; all regs use the _reg/_next style.
// TESTING
//  (Use MOVE_DIV=4, TIMEOUT=16.)
//  1. Reset, then no stimulus -> left=right=left_held=right_held=0 for 100 cycles.
//  2. Bytes E0,6B -> left_held=1 the cycle after 6B; left pulses at +2,+6,+10.
//     Bytes E0,F0,6B -> left_held=0 and no further pulses.
//  3. 1C then 23 (A and D held) -> left and right pulse in the same cycles.
//     F0,1C -> only right keeps pulsing, on unchanged cadence.
//  4. E0, 20 idle cycles, then 6B -> FSM timed out, so 6B is ignored: left_held stays 0.
//  5. E0,6B repeated 5x (typematic) -> single continuous left_held; pulse spacing
//     stays exactly 4.
//  6. E0,74 held; assert reset mid E0,F0 sequence -> all outputs 0 at once.
//     A following 74 is ignored.

Source files
------------

// File: rtl/player_key_decoder_pkg.sv
// Shared scancode constants and decoder FSM state encoding for the player key decoder.
package player_key_decoder_pkg;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] ScExt      = 8'hE0;
  localparam logic [7:0] ScBrk      = 8'hF0;

  // Default direction keys: extended arrows and the plain A/D alternates
  localparam logic [7:0] ScLeft     = 8'h6B;
  localparam logic [7:0] ScRight    = 8'h74;
  localparam logic [7:0] ScAltLeft  = 8'h1C;
  localparam logic [7:0] ScAltRight = 8'h23;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } dec_state_e;

endpackage

// File: rtl/player_key_decoder_move_rate_tick.sv
// Rate limiter: one move pulse per MOVE_DIV clocks on each held direction, shared cadence.
module player_key_decoder_move_rate_tick #(
  parameter int unsigned MOVE_DIV = 200_000
) (
  input  logic clk,
  input  logic reset,
  input  logic held_l,
  input  logic held_r,
  output logic left,
  output logic right
);

  localparam int unsigned CntW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MOVE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            right_q, right_d;

  // Counter free-runs only while any key is held, so a fresh press starts at zero
  always_comb begin
    cnt_d   = cnt_q;
    left_d  = held_l & (cnt_q == '0);
    right_d = held_r & (cnt_q == '0);
    if (!(held_l | held_r)) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and registered pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left  = left_q;
  assign right = right_q;

endmodule

// File: rtl/player_key_decoder.sv
// PS/2 byte stream -> held-direction flags and rate-limited left/right move pulses.
module player_key_decoder
  import player_key_decoder_pkg::*;
#(
  parameter int unsigned MOVE_DIV   = 200_000,
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter logic [7:0]  CODE_LEFT  = ScLeft,
  parameter logic [7:0]  CODE_RIGHT = ScRight,
  parameter logic [7:0]  ALT_LEFT   = ScAltLeft,
  parameter logic [7:0]  ALT_RIGHT  = ScAltRight
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       left,
  output logic       right,
  output logic       left_held,
  output logic       right_held
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT - 1);

  dec_state_e      state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            lheld_q, lheld_d;
  logic            rheld_q, rheld_d;

  // Decode make/break/extended sequences; abort a stale prefix after TIMEOUT idle clocks
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    lheld_d = lheld_q;
    rheld_d = rheld_q;

    if (rx_done_tick) begin
      state_d = StIdle;
      unique case (state_q)
        StIdle: begin
          if (rx_data == ScExt) begin
            state_d = StExt;
          end else if (rx_data == ScBrk) begin
            state_d = StBrk;
          end else if (rx_data == ALT_LEFT) begin
            lheld_d = 1'b1;
          end else if (rx_data == ALT_RIGHT) begin
            rheld_d = 1'b1;
          end
        end
        StExt: begin
          if (rx_data == ScBrk) begin
            state_d = StExtBrk;
          end else if (rx_data == ScExt) begin
            state_d = StExt;
          end else if (rx_data == CODE_LEFT) begin
            lheld_d = 1'b1;
          end else if (rx_data == CODE_RIGHT) begin
            rheld_d = 1'b1;
          end
        end
        StBrk: begin
          if (rx_data == ScExt) begin
            state_d = StExtBrk;
          end else if (rx_data == ALT_LEFT) begin
            lheld_d = 1'b0;
          end else if (rx_data == ALT_RIGHT) begin
            rheld_d = 1'b0;
          end
        end
        StExtBrk: begin
          if (rx_data == CODE_LEFT) begin
            lheld_d = 1'b0;
          end else if (rx_data == CODE_RIGHT) begin
            rheld_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Timeout counter only runs while a prefix is pending; any byte restarts it
    if (state_q == StIdle || rx_done_tick) begin
      tmo_d = '0;
    end else if (tmo_q == TmoMax) begin
      tmo_d   = '0;
      state_d = StIdle;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Decoder state, timeout counter and held flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      lheld_q <= 1'b0;
      rheld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      lheld_q <= lheld_d;
      rheld_q <= rheld_d;
    end
  end

  assign left_held  = lheld_q;
  assign right_held = rheld_q;

  player_key_decoder_move_rate_tick #(
    .MOVE_DIV (MOVE_DIV)
  ) u_move_rate_tick (
    .clk    (clk),
    .reset  (reset),
    .held_l (lheld_q),
    .held_r (rheld_q),
    .left   (left),
    .right  (right)
  );

endmodule

// File: tb/tb_player_key_decoder.sv
// Directed bench for player_key_decoder with MOVE_DIV=4, TIMEOUT=16.
module tb_player_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       left, right, left_held, right_held;
  logic [3:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {left, right, left_held, right_held};

  player_key_decoder #(
    .MOVE_DIV (4),
    .TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .left         (left),
    .right        (right),
    .left_held    (left_held),
    .right_held   (right_held)
  );

  // obs/exp bit order: {left, right, left_held, right_held}
  task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was accepted
  task automatic send(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic p;

    // 1. Reset and quiet line
    idle(2);
    check("reset_outs", obs, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("quiet", obs, 4'b0000);
      @(negedge clk);
    end

    // 2. Extended left press: held at t=1, pulses at t=2,6,10
    send(8'hE0);
    send(8'h6B);
    for (int t = 1; t <= 12; t++) begin
      p = (t % 4 == 2);
      check("ext_left_cadence", obs, {p, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("ext_left_release_held", obs & 4'b0011, 4'b0000);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check("ext_left_no_pulse", obs, 4'b0000);
      @(negedge clk);
    end

    // 3. A then D held: shared cadence, then release A
    send(8'h1C);
    send(8'h23);
    check("both_first", obs, 4'b1011);
    for (int t = 3; t <= 16; t++) begin
      @(negedge clk);
      p = (t % 4 == 2);
      check("both_cadence", obs, {p, p, 1'b1, 1'b1});
    end
    send(8'hF0);
    send(8'h1C);
    check("release_a_edge", obs, 4'b1101);
    for (int t = 19; t <= 30; t++) begin
      @(negedge clk);
      p = (t % 4 == 2);
      check("right_only_cadence", obs, {1'b0, p, 1'b0, 1'b1});
    end
    send(8'hF0);
    send(8'h23);
    idle(2);
    check("all_released", obs, 4'b0000);

    // 4. Prefix timeout: stale E0 is dropped; a prompt one is still honoured
    send(8'hE0);
    idle(20);
    send(8'h6B);
    check("timeout_ignored", obs, 4'b0000);
    idle(3);
    check("timeout_still_idle", obs, 4'b0000);
    send(8'hE0);
    idle(10);
    send(8'h6B);
    check("within_timeout", obs & 4'b0011, 4'b0010);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    idle(2);
    check("within_timeout_release", obs, 4'b0000);

    // 5. Typematic repeat keeps exact 4-cycle spacing
    send(8'hE0);
    send(8'h6B);
    for (int t = 1; t <= 20; t++) begin
      p = (t % 4 == 2);
      check("typematic_cadence", obs, {p, 1'b0, 1'b1, 1'b0});
      if (t <= 8) begin
        rx_data      = (t % 2 == 1) ? 8'hE0 : 8'h6B;
        rx_done_tick = 1'b1;
      end else begin
        rx_done_tick = 1'b0;
      end
      @(negedge clk);
    end
    rx_done_tick = 1'b0;
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    idle(2);
    check("typematic_release", obs, 4'b0000);

    // 6. Asynchronous reset in the middle of an E0,F0 sequence
    send(8'hE0);
    send(8'h74);
    check("ext_right_held", obs & 4'b0011, 4'b0001);
    idle(3);
    send(8'hE0);
    rx_data      = 8'hF0;
    rx_done_tick = 1'b1;
    reset        = 1'b1;
    #1;
    check("async_reset", obs, 4'b0000);
    @(negedge clk);
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    send(8'h74);
    for (int i = 0; i < 8; i++) begin
      check("post_reset_74_ignored", obs, 4'b0000);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
